fsm_mealy_sched: RTL

FSM_MEALY_SCHED -- requirements
Module: fsm_mealy_sched

---
 rtl/fsm_mealy_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fsm_mealy_sched.sv
// fsm_mealy_sched: one "110" overlapping Mealy detector time-shared across
// four serial channels. Each channel keeps its own 2-bit detector state; a
// round-robin arbiter picks one eligible channel per cycle and only that
// channel's state advances. Detections are reported one cycle later as a
// registered pulse tagged with the channel index.
//
// Optional feature: define FSM_SCHED_CNT_EN to add four saturating CNT_W-bit
// per-channel match counters with a cnt_sel_i / cnt_value_o readout port.
module fsm_mealy_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       in_valid_i,
    input  logic [3:0]       in_bit_i,
    output logic [3:0]       in_ready_o,
    input  logic [3:0]       ch_clear_i,
`ifdef FSM_SCHED_CNT_EN
    input  logic [1:0]       cnt_sel_i,
    output logic [CNT_W-1:0] cnt_value_o,
`endif
    output logic             detect_o,
    output logic [1:0]       detect_ch_o
);

    // Detector states: S0 idle, S1 seen "1", S2 seen "11".
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } detState_e;

    detState_e  chState_q [4];
    logic [1:0] ptr_q;
    logic       detect_q;
    logic [1:0] detectCh_q;

    logic [3:0] eligible;
    logic       grantValid_d;
    logic [1:0] grantIdx_d;
    logic [1:0] scanIdx;
    detState_e  curState;
    logic       curBit;
    detState_e  nextState_d;
    logic       match_d;

    assign eligible = in_valid_i & ~ch_clear_i;

    // Round-robin pick: first eligible channel at or after the pointer; nothing while in reset.
    always_comb begin
        grantValid_d = 1'b0;
        grantIdx_d   = 2'd0;
        scanIdx      = 2'd0;
        if (!reset_i) begin
            for (int k = 0; k < 4; k++) begin
                scanIdx = ptr_q + 2'(k);
                if (!grantValid_d && eligible[scanIdx]) begin
                    grantValid_d = 1'b1;
                    grantIdx_d   = scanIdx;
                end
            end
        end
    end

    assign in_ready_o = grantValid_d ? (4'b0001 << grantIdx_d) : 4'b0000;

    // Mealy next-state and match for the bit offered by the granted channel.
    always_comb begin
        curState    = chState_q[grantIdx_d];
        curBit      = in_bit_i[grantIdx_d];
        nextState_d = S0;
        match_d     = 1'b0;
        case (curState)
            S0: nextState_d = curBit ? S1 : S0;
            S1: nextState_d = curBit ? S2 : S0;
            S2: begin
                nextState_d = curBit ? S2 : S0;
                match_d     = ~curBit;
            end
            default: nextState_d = S0;
        endcase
    end

    // Saved channel states, arbitration pointer and the registered detect pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 4; i++) begin
                chState_q[i] <= S0;
            end
            ptr_q      <= 2'd0;
            detect_q   <= 1'b0;
            detectCh_q <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ch_clear_i[i]) begin
                    chState_q[i] <= S0;
                end else if (grantValid_d && (grantIdx_d == 2'(i))) begin
                    chState_q[i] <= nextState_d;
                end
            end
            if (grantValid_d) begin
                ptr_q <= grantIdx_d + 2'd1;
            end
            detect_q   <= grantValid_d & match_d;
            detectCh_q <= (grantValid_d && match_d) ? grantIdx_d : 2'd0;
        end
    end

    assign detect_o    = detect_q;
    assign detect_ch_o = detectCh_q;

`ifdef FSM_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];

    // Per-channel match counters: bump alongside the detect pulse, saturate, clear with the channel.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ch_clear_i[i]) begin
                    cnt_q[i] <= '0;
                end else if (grantValid_d && match_d && (grantIdx_d == 2'(i))
                             && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign cnt_value_o = cnt_q[cnt_sel_i];
`else
    // Without counters, matches are only visible through detect_o / detect_ch_o.
`endif

endmodule
